// File: rtl/dec_perf_if.sv
// Receiver-side bundle for the dec_perf serial frame decoder.
// Ports: en, serial_in, data_ready in; data_out, data_valid, frame_err, busy out.
interface dec_perf_if #(
    parameter int DATA_BITS = 4
);
    logic                 en;
    logic                 serial_in;
    logic                 data_ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output en,
        output serial_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  en,
        input  serial_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/dec_perf.sv
// Serial frame decoder: start 1, DATA_BITS LSB-first, stop 0, word held until taken.
// Ports: clk, rst_n (async low), bus (slave): en/serial_in/data_ready in, word/flags out.
module dec_perf #(
    parameter int DATA_BITS    = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    dec_perf_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.en && bus.serial_in) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // Sample mid start bit so later samples land mid-bit.
            S_START: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (bus.serial_in) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (idx_q == IW'(i)) begin
                            shift_d[i] = bus.serial_in;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (!bus.serial_in) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Word stays put regardless of en/serial_in until taken.
            S_HOLD: begin
                if (bus.data_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q == S_START) ||
                            (state_q == S_DATA)  ||
                            (state_q == S_STOP);
endmodule

// File: tb/tb_dec_perf.sv
// Randomized bench for dec_perf against a frame-level expectation model.
// Drives on negedge, samples on negedge before driving.
module tb_dec_perf;
    localparam int DB  = 4;
    localparam int CPB = 4;
    localparam int LAT = CPB / 2 + (DB + 1) * CPB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dec_perf_if #(.DATA_BITS(DB)) bus ();

    dec_perf #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int rise_cnt, rise_at, err_cnt, busy_cnt;
    logic v_prev = 1'b0;
    logic [DB-1:0] exp_dout = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (bus.frame_err) err_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.data_valid && !v_prev) begin
            rise_cnt++;
            rise_at = ncyc;
        end
        v_prev = bus.data_valid;
    endtask

    task automatic clr_obs();
        rise_cnt = 0;
        err_cnt  = 0;
        busy_cnt = 0;
        rise_at  = -1;
    endtask

    // ab: data bit index during which en drops (-1: none)
    // acc: take the pending word on the start edge of this frame
    task automatic send(input logic [DB-1:0] d, input logic stp,
                        input int ab, input bit acc, input bit rst_stop,
                        output int start);
        logic [DB+1:0] bits;
        bits  = {stp, d, 1'b1};
        clr_obs();
        start = ncyc;
        for (int b = 0; b < DB + 2; b++) begin
            for (int c = 0; c < CPB; c++) begin
                bus.serial_in = bits[b];
                if (acc && b == 0) bus.data_ready = (c == 0);
                if (ab >= 0 && b == ab + 1 && c == 1) bus.en = 1'b0;
                if (rst_stop && b == DB + 1 && c == 1) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_valid", 32'(bus.data_valid), 0);
                    chk("rst_err", 32'(bus.frame_err), 0);
                    chk("rst_busy", 32'(bus.busy), 0);
                    chk("rst_dout", 32'(bus.data_out), 0);
                    exp_dout = '0;
                    #1 rst_n = 1'b1;
                end
                tick();
            end
        end
        bus.serial_in = 1'b0;
        bus.en        = 1'b1;
    endtask

    task automatic expect_frame(input logic [DB-1:0] d, input logic stp,
                                input bit dropped, input int start,
                                input int extra);
        tick();
        tick();
        if (dropped) begin
            chk("drop_valid", rise_cnt, 0);
            chk("drop_err", err_cnt, 0);
            chk("drop_dout", 32'(bus.data_out), 32'(exp_dout));
            chk("drop_busy", 32'(bus.busy), 0);
        end else if (stp) begin
            chk("err_pulse", err_cnt, 1);
            chk("err_valid", rise_cnt, 0);
            chk("err_dout", 32'(bus.data_out), 32'(exp_dout));
        end else begin
            exp_dout = d;
            chk("valid_rise", rise_cnt, 1);
            chk("latency", rise_at - start, LAT + 1 + extra);
            chk("data", 32'(bus.data_out), 32'(exp_dout));
            chk("no_err", err_cnt, 0);
        end
    endtask

    // Noise on serial_in/en while holding, then a one-cycle accept.
    task automatic hold_accept(input int n);
        for (int i = 0; i < n; i++) begin
            bus.serial_in = 1'($urandom_range(0, 1));
            bus.en        = 1'($urandom_range(0, 1));
            tick();
            chk("hold_valid", 32'(bus.data_valid), 1);
            chk("hold_dout", 32'(bus.data_out), 32'(exp_dout));
        end
        bus.serial_in  = 1'b0;
        bus.en         = 1'b1;
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("acc_valid", 32'(bus.data_valid), 0);
        chk("acc_dout", 32'(bus.data_out), 32'(exp_dout));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        logic [DB-1:0] d;
        logic stp;
        int ab;

        rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.serial_in  = 1'b0;
        bus.data_ready = 1'b0;
        clr_obs();
        tick();
        tick();
        chk("reset_valid", 32'(bus.data_valid), 0);
        chk("reset_err", 32'(bus.frame_err), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_dout", 32'(bus.data_out), 0);
        rst_n = 1'b1;
        tick();

        send(4'hB, 1'b0, -1, 1'b0, 1'b0, st);
        expect_frame(4'hB, 1'b0, 1'b0, st, 0);
        hold_accept(4);

        send(4'h6, 1'b0, -1, 1'b0, 1'b0, st);
        expect_frame(4'h6, 1'b0, 1'b0, st, 0);
        hold_accept(1);

        // Accept and new start on the same edge: detection slips a cycle.
        send(4'h9, 1'b0, -1, 1'b0, 1'b0, st);
        expect_frame(4'h9, 1'b0, 1'b0, st, 0);
        send(4'h5, 1'b0, -1, 1'b1, 1'b0, st);
        expect_frame(4'h5, 1'b0, 1'b0, st, 1);
        hold_accept(0);

        // data_ready with nothing pending
        bus.data_ready = 1'b1;
        tick();
        tick();
        bus.data_ready = 1'b0;
        chk("idle_ready_valid", 32'(bus.data_valid), 0);
        chk("idle_ready_dout", 32'(bus.data_out), 32'(exp_dout));

        // One-cycle glitch
        clr_obs();
        bus.serial_in = 1'b1;
        tick();
        bus.serial_in = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("glitch_busy", busy_cnt, CPB / 2);
        chk("glitch_valid", rise_cnt, 0);
        chk("glitch_err", err_cnt, 0);

        send(4'h3, 1'b1, -1, 1'b0, 1'b0, st);
        expect_frame(4'h3, 1'b1, 1'b0, st, 0);

        send(4'hA, 1'b0, 2, 1'b0, 1'b0, st);
        expect_frame(4'hA, 1'b0, 1'b1, st, 0);
        send(4'hC, 1'b0, -1, 1'b0, 1'b0, st);
        expect_frame(4'hC, 1'b0, 1'b0, st, 0);
        hold_accept(2);

        for (int n = 0; n < 30; n++) begin
            d   = DB'($urandom);
            stp = ($urandom_range(0, 4) == 0);
            ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DB - 1)) : -1;
            repeat ($urandom_range(0, 3)) tick();
            send(d, stp, ab, 1'b0, 1'b0, st);
            expect_frame(d, stp, ab >= 0, st, 0);
            if (ab < 0 && !stp) hold_accept($urandom_range(0, 5));
        end

        send(4'hF, 1'b0, -1, 1'b0, 1'b1, st);
        tick();
        tick();
        chk("post_rst_rise", rise_cnt, 0);
        chk("post_rst_valid", 32'(bus.data_valid), 0);
        chk("post_rst_dout", 32'(bus.data_out), 32'(exp_dout));

        send(4'h7, 1'b0, -1, 1'b0, 1'b0, st);
        expect_frame(4'h7, 1'b0, 1'b0, st, 0);
        hold_accept(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_perf.md
DEC_PERF -- requirements
Module: dec_perf

Interface
REQ-001 SHALL have parameter DATA_BITS, default 4: number of payload bits per frame, range 1..8.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; even and >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: functionality-2 enable; high means receive, low means abort or ignore.
REQ-006 SHALL have port serial_in, input, 1 bit: serial line from the peripheral encoder; idle level 0.
REQ-007 SHALL have port data_ready, input, 1 bit: consumer accepts the held word.
REQ-008 SHALL have port data_out, output, DATA_BITS bits: received word, LSB received first.
REQ-009 SHALL have port data_valid, output, 1 bit: data_out holds a complete, unconsumed frame.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port busy, output, 1 bit: high in START, DATA and STOP.

Function
REQ-012 SHALL use the frame format: start bit 1, then DATA_BITS data bits LSB first, then stop bit 0.
REQ-013 SHALL implement an FSM with states IDLE, START, DATA, STOP and HOLD, plus a bit-period counter cnt and a bit index idx.
REQ-014 IDLE SHALL go to START with cnt=0 on an edge where en=1 and serial_in=1; otherwise it SHALL stay in IDLE.
REQ-015 START SHALL increment cnt each cycle, and at cnt==CLKS_PER_BIT/2-1 SHALL sample serial_in.
REQ-016 On that START sample, serial_in=1 SHALL go to DATA with cnt=0 and idx=0; serial_in=0 (glitch) SHALL return to IDLE with no flag.
REQ-017 DATA SHALL sample serial_in at cnt==CLKS_PER_BIT-1 into bit idx of a shift register, reset cnt to 0 and increment idx.
REQ-018 DATA SHALL go to STOP after the DATA_BITS-th sample.
REQ-019 STOP SHALL sample serial_in at cnt==CLKS_PER_BIT-1.
REQ-020 A STOP sample of 0 SHALL load data_out, set data_valid=1 and go to HOLD.
REQ-021 A STOP sample of 1 SHALL pulse frame_err for exactly one cycle, go to IDLE and leave data_out and data_valid unchanged.
REQ-022 data_valid SHALL rise exactly CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the START entry edge; this is 22 cycles at the defaults.
REQ-023 HOLD SHALL keep data_valid=1 and data_out stable while data_ready=0, and SHALL ignore serial_in.
REQ-024 HOLD with data_ready=1 SHALL clear data_valid on that edge and go to IDLE; a start bit on the same edge SHALL NOT be detected until the next cycle.
REQ-025 data_ready while data_valid=0 SHALL have no effect.
REQ-026 en=0 in START, DATA or STOP SHALL force IDLE on the next edge, discard the partial frame and assert no flag.
REQ-027 en=0 SHALL NOT affect HOLD; the pending word remains until accepted.
REQ-028 data_out SHALL change only on the STOP-to-HOLD transition.
REQ-029 busy SHALL be combinationally decoded from the state.
REQ-030 All other outputs SHALL be registered.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force IDLE, cnt=0, idx=0, data_out=0, data_valid=0, frame_err=0 and busy=0.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard all state.
REQ-033 After rst_n rises, the first start detection SHALL occur no earlier than the first rising edge following release.

Verification
REQ-034 Defaults, en=1, frame 1 | 1,1,0,1 | 0 with each bit held 4 cycles, data_ready=0 -> data_valid=1 and data_out=4'hB, 22 cycles after START entry, then held.
REQ-035 From that held state, data_ready=1 for one cycle -> data_valid=0 next edge; a second frame carrying 4'h6 is then received correctly.
REQ-036 serial_in high for 1 cycle only while idle -> START sample reads 0, return to IDLE; busy high for 2 cycles; data_valid and frame_err remain 0.
REQ-037 Frame 4'h3 with stop bit 1 -> frame_err high for exactly 1 cycle; data_valid stays 0; data_out keeps its previous value.
REQ-038 en dropped to 0 during data bit 2 -> IDLE next edge with no valid or err; a frame with en=1 afterwards is received correctly.
REQ-039 rst_n pulsed low during the STOP bit of a 4'hF frame -> all outputs 0 asynchronously; no data_valid after release.
